// File: rtl/riscv_pipe_pkg.sv
// Shared pipeline types for the 5-stage RV32I core: the ID/EX control bundle
// and the encodings of its fields.
package riscv_pipe_pkg;

   typedef struct packed {
      logic       regWrite;
      logic [1:0] resultSrc;
      logic       MemWrite;
      logic       Jump;
      logic       Branch;
      logic [2:0] ALUControl;
      logic       ALUSrc;
   } id_ex_ctrl_t;

   localparam logic [1:0] RESULT_ALU = 2'b00;
   localparam logic [1:0] RESULT_MEM = 2'b01;
   localparam logic [1:0] RESULT_PC4 = 2'b10;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b101;

   localparam id_ex_ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/pipe_reg_en_clr.sv
// W-bit pipeline flop: async reset, synchronous clear with priority over enable.
module pipe_reg_en_clr #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         i_en,
   input  logic         i_clr,
   input  logic [W-1:0] i_d,
   output logic [W-1:0] o_q
);

   logic [W-1:0] r_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)      r_q <= '0;
      else if (i_clr) r_q <= '0;
      else if (i_en)  r_q <= i_d;
   end

   assign o_q = r_q;

endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register: carries the decode control bundle and operands into
// execute, with stall/flush and issue/bubble counters.
module id_ex_pipe_reg
   import riscv_pipe_pkg::*;
#(
   parameter int word_width = 32,
   parameter int CNT_W      = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  StallE,
   input  logic                  FlushE,
   input  logic                  validD,
   input  logic                  regWriteD,
   input  logic [1:0]            resultSrcD,
   input  logic                  MemWriteD,
   input  logic                  JumpD,
   input  logic                  BranchD,
   input  logic [2:0]            ALUControlD,
   input  logic                  ALUSrcD,
   input  logic [word_width-1:0] RD1D,
   input  logic [word_width-1:0] RD2D,
   input  logic [word_width-1:0] PCD,
   input  logic [word_width-1:0] PCPlus4D,
   input  logic [word_width-1:0] ImmExtD,
   input  logic [4:0]            Rs1D,
   input  logic [4:0]            Rs2D,
   input  logic [4:0]            RdD,
   output logic                  validE,
   output logic                  regWriteE,
   output logic [1:0]            resultSrcE,
   output logic                  MemWriteE,
   output logic                  JumpE,
   output logic                  BranchE,
   output logic [2:0]            ALUControlE,
   output logic                  ALUSrcE,
   output logic [word_width-1:0] RD1E,
   output logic [word_width-1:0] RD2E,
   output logic [word_width-1:0] PCE,
   output logic [word_width-1:0] PCPlus4E,
   output logic [word_width-1:0] ImmExtE,
   output logic [4:0]            Rs1E,
   output logic [4:0]            Rs2E,
   output logic [4:0]            RdE,
   output logic [CNT_W-1:0]      issue_cnt,
   output logic [CNT_W-1:0]      bubble_cnt
);

   localparam int CTRL_BITS = $bits(id_ex_ctrl_t) + 1;
   localparam int DATA_BITS = 5 * word_width + 15;
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   id_ex_ctrl_t          w_ctrl_d;
   id_ex_ctrl_t          w_ctrl_q;
   logic [CTRL_BITS-1:0] w_cv_q;
   logic [DATA_BITS-1:0] w_data_q;
   logic                 w_issue;
   logic                 w_bubble;
   logic [CNT_W-1:0]     r_issue_cnt;
   logic [CNT_W-1:0]     r_bubble_cnt;

   // An invalid slot carries a zeroed bundle so it can never write regfile or memory.
   always_comb begin
      w_ctrl_d = CTRL_BUBBLE;
      if (validD) begin
         w_ctrl_d.regWrite   = regWriteD;
         w_ctrl_d.resultSrc  = resultSrcD;
         w_ctrl_d.MemWrite   = MemWriteD;
         w_ctrl_d.Jump       = JumpD;
         w_ctrl_d.Branch     = BranchD;
         w_ctrl_d.ALUControl = ALUControlD;
         w_ctrl_d.ALUSrc     = ALUSrcD;
      end
   end

   pipe_reg_en_clr #(.W(CTRL_BITS)) u_ctrl_reg (
      .clk   (clk),
      .reset (reset),
      .i_en  (!StallE),
      .i_clr (FlushE),
      .i_d   ({validD, w_ctrl_d}),
      .o_q   (w_cv_q)
   );

   pipe_reg_en_clr #(.W(DATA_BITS)) u_data_reg (
      .clk   (clk),
      .reset (reset),
      .i_en  (!StallE),
      .i_clr (FlushE),
      .i_d   ({RD1D, RD2D, PCD, PCPlus4D, ImmExtD, Rs1D, Rs2D, RdD}),
      .o_q   (w_data_q)
   );

   assign {validE, w_ctrl_q} = w_cv_q;
   assign regWriteE   = w_ctrl_q.regWrite;
   assign resultSrcE  = w_ctrl_q.resultSrc;
   assign MemWriteE   = w_ctrl_q.MemWrite;
   assign JumpE       = w_ctrl_q.Jump;
   assign BranchE     = w_ctrl_q.Branch;
   assign ALUControlE = w_ctrl_q.ALUControl;
   assign ALUSrcE     = w_ctrl_q.ALUSrc;
   assign {RD1E, RD2E, PCE, PCPlus4E, ImmExtE, Rs1E, Rs2E, RdE} = w_data_q;

   // A flush under stall still delivers (and counts) a bubble.
   assign w_issue  = !FlushE && !StallE && validD;
   assign w_bubble = FlushE || (!StallE && !validD);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_issue_cnt  <= '0;
         r_bubble_cnt <= '0;
      end else begin
         if (w_issue)  r_issue_cnt  <= r_issue_cnt + CNT_ONE;
         if (w_bubble) r_bubble_cnt <= r_bubble_cnt + CNT_ONE;
      end
   end

   assign issue_cnt  = r_issue_cnt;
   assign bubble_cnt = r_bubble_cnt;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Directed, table-driven bench for id_ex_pipe_reg (counters built 4 bits wide
// so the wrap point is reachable).
module tb_id_ex_pipe_reg;

   localparam int WW = 32;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          StallE, FlushE, validD, regWriteD, MemWriteD, JumpD, BranchD, ALUSrcD;
   logic [1:0]    resultSrcD;
   logic [2:0]    ALUControlD;
   logic [WW-1:0] RD1D, RD2D, PCD, PCPlus4D, ImmExtD;
   logic [4:0]    Rs1D, Rs2D, RdD;
   logic          validE, regWriteE, MemWriteE, JumpE, BranchE, ALUSrcE;
   logic [1:0]    resultSrcE;
   logic [2:0]    ALUControlE;
   logic [WW-1:0] RD1E, RD2E, PCE, PCPlus4E, ImmExtE;
   logic [4:0]    Rs1E, Rs2E, RdE;
   logic [CW-1:0] issue_cnt, bubble_cnt;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   id_ex_pipe_reg #(.word_width(WW), .CNT_W(CW)) dut (
      .clk(clk), .reset(reset), .StallE(StallE), .FlushE(FlushE), .validD(validD),
      .regWriteD(regWriteD), .resultSrcD(resultSrcD), .MemWriteD(MemWriteD),
      .JumpD(JumpD), .BranchD(BranchD), .ALUControlD(ALUControlD), .ALUSrcD(ALUSrcD),
      .RD1D(RD1D), .RD2D(RD2D), .PCD(PCD), .PCPlus4D(PCPlus4D), .ImmExtD(ImmExtD),
      .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
      .validE(validE), .regWriteE(regWriteE), .resultSrcE(resultSrcE),
      .MemWriteE(MemWriteE), .JumpE(JumpE), .BranchE(BranchE),
      .ALUControlE(ALUControlE), .ALUSrcE(ALUSrcE),
      .RD1E(RD1E), .RD2E(RD2E), .PCE(PCE), .PCPlus4E(PCPlus4E), .ImmExtE(ImmExtE),
      .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
      .issue_cnt(issue_cnt), .bubble_cnt(bubble_cnt)
   );

   typedef struct {
      logic        st, fl, v, rw, mw, jp;
      logic [4:0]  rd;
      logic [31:0] rd1;
      logic        e_v, e_rw, e_mw, e_jp;
      logic [4:0]  e_rd;
      logic [31:0] e_rd1;
      int          e_ic, e_bc;
   } vec_t;

   vec_t tv[11];

   function automatic vec_t mk(input logic st, fl, v, rw, mw, jp, input logic [4:0] rd,
                               input logic [31:0] rd1, input logic e_v, e_rw, e_mw, e_jp,
                               input logic [4:0] e_rd, input logic [31:0] e_rd1,
                               input int e_ic, e_bc);
      vec_t t;
      t.st = st; t.fl = fl; t.v = v; t.rw = rw; t.mw = mw; t.jp = jp; t.rd = rd; t.rd1 = rd1;
      t.e_v = e_v; t.e_rw = e_rw; t.e_mw = e_mw; t.e_jp = e_jp; t.e_rd = e_rd;
      t.e_rd1 = e_rd1; t.e_ic = e_ic; t.e_bc = e_bc;
      return t;
   endfunction

   function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [4:0] rs1_of(input logic [4:0] r);
      return {r[0], r[4:1]};
   endfunction

   function automatic logic [4:0] rs2_of(input logic [4:0] r);
      return {r[3:0], r[4]};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Drives every D input from a compact row; side fields are derived so they can be predicted.
   task automatic drive(input logic st, fl, v, rw, mw, jp, input logic [4:0] rd,
                        input logic [31:0] rd1);
      StallE = st; FlushE = fl; validD = v;
      regWriteD = rw; MemWriteD = mw; JumpD = jp; BranchD = jp;
      resultSrcD = 2'b10; ALUControlD = {jp, mw, rw}; ALUSrcD = mw;
      RD1D = rd1; RD2D = rotr(rd1, 16); PCD = rotr(rd1, 8);
      PCPlus4D = rotr(rd1, 24); ImmExtD = rotr(rd1, 4);
      RdD = rd; Rs1D = rs1_of(rd); Rs2D = rs2_of(rd);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, ".validE"}, {31'd0, validE}, 0);
      chk({tag, ".ctrl"}, {22'd0, regWriteE, resultSrcE, MemWriteE, JumpE, BranchE,
                           ALUControlE, ALUSrcE}, 0);
      chk({tag, ".RD1E"}, RD1E, 0);
      chk({tag, ".RD2E|PCE|PCPlus4E|ImmExtE"}, RD2E | PCE | PCPlus4E | ImmExtE, 0);
      chk({tag, ".regidx"}, {17'd0, Rs1E, Rs2E, RdE}, 0);
      chk({tag, ".issue_cnt"}, {28'd0, issue_cnt}, 0);
      chk({tag, ".bubble_cnt"}, {28'd0, bubble_cnt}, 0);
   endtask

   initial begin
      tv[0]  = mk(0,0,1,1,0,0, 5'd5,  32'hDEADBEEF, 1,1,0,0, 5'd5,  32'hDEADBEEF, 1, 0);
      tv[1]  = mk(0,0,1,0,0,0, 5'd7,  32'h11111111, 1,0,0,0, 5'd7,  32'h11111111, 2, 0);
      tv[2]  = mk(1,0,1,1,0,0, 5'd9,  32'h99999999, 1,0,0,0, 5'd7,  32'h11111111, 2, 0);
      tv[3]  = mk(1,0,1,1,0,0, 5'd9,  32'h99999999, 1,0,0,0, 5'd7,  32'h11111111, 2, 0);
      tv[4]  = mk(1,0,1,1,0,0, 5'd9,  32'h99999999, 1,0,0,0, 5'd7,  32'h11111111, 2, 0);
      tv[5]  = mk(0,0,1,1,0,0, 5'd9,  32'h99999999, 1,1,0,0, 5'd9,  32'h99999999, 3, 0);
      tv[6]  = mk(1,1,1,0,1,0, 5'd3,  32'h33333333, 0,0,0,0, 5'd0,  32'h0,        3, 1);
      tv[7]  = mk(0,0,0,1,0,1, 5'd4,  32'h44444444, 0,0,0,0, 5'd4,  32'h44444444, 3, 2);
      tv[8]  = mk(1,0,0,1,1,1, 5'd6,  32'h66666666, 0,0,0,0, 5'd4,  32'h44444444, 3, 2);
      tv[9]  = mk(0,1,1,1,1,1, 5'd8,  32'h88888888, 0,0,0,0, 5'd0,  32'h0,        3, 3);
      tv[10] = mk(0,0,1,0,1,1, 5'd31, 32'hFFFFFFFF, 1,0,1,1, 5'd31, 32'hFFFFFFFF, 4, 3);

      reset = 1'b1;
      drive(0,0,0,0,0,0, 5'd0, 32'h0);
      #1;
      chk_all_zero("reset0");
      @(negedge clk);
      reset = 1'b0;

      foreach (tv[i]) begin
         drive(tv[i].st, tv[i].fl, tv[i].v, tv[i].rw, tv[i].mw, tv[i].jp, tv[i].rd, tv[i].rd1);
         @(posedge clk);
         #1;
         chk($sformatf("v%0d.validE", i),     {31'd0, validE},    {31'd0, tv[i].e_v});
         chk($sformatf("v%0d.regWriteE", i),  {31'd0, regWriteE}, {31'd0, tv[i].e_rw});
         chk($sformatf("v%0d.MemWriteE", i),  {31'd0, MemWriteE}, {31'd0, tv[i].e_mw});
         chk($sformatf("v%0d.JumpE", i),      {31'd0, JumpE},     {31'd0, tv[i].e_jp});
         chk($sformatf("v%0d.BranchE", i),    {31'd0, BranchE},   {31'd0, tv[i].e_jp});
         chk($sformatf("v%0d.ALUCtrlE", i),   {29'd0, ALUControlE},
             {29'd0, tv[i].e_jp, tv[i].e_mw, tv[i].e_rw});
         chk($sformatf("v%0d.ALUSrcE", i),    {31'd0, ALUSrcE},   {31'd0, tv[i].e_mw});
         chk($sformatf("v%0d.resultSrcE", i), {30'd0, resultSrcE},
             tv[i].e_v ? 32'd2 : 32'd0);
         chk($sformatf("v%0d.RdE", i),        {27'd0, RdE},       {27'd0, tv[i].e_rd});
         chk($sformatf("v%0d.Rs1E", i),       {27'd0, Rs1E},      {27'd0, rs1_of(tv[i].e_rd)});
         chk($sformatf("v%0d.Rs2E", i),       {27'd0, Rs2E},      {27'd0, rs2_of(tv[i].e_rd)});
         chk($sformatf("v%0d.RD1E", i),       RD1E,               tv[i].e_rd1);
         chk($sformatf("v%0d.RD2E", i),       RD2E,               rotr(tv[i].e_rd1, 16));
         chk($sformatf("v%0d.PCE", i),        PCE,                rotr(tv[i].e_rd1, 8));
         chk($sformatf("v%0d.PCPlus4E", i),   PCPlus4E,           rotr(tv[i].e_rd1, 24));
         chk($sformatf("v%0d.ImmExtE", i),    ImmExtE,            rotr(tv[i].e_rd1, 4));
         chk($sformatf("v%0d.issue_cnt", i),  {28'd0, issue_cnt}, tv[i].e_ic);
         chk($sformatf("v%0d.bubble_cnt", i), {28'd0, bubble_cnt}, tv[i].e_bc);
      end

      // Mid-cycle async reset while stalled: everything clears before any edge.
      #3;
      drive(1,0,1,1,1,1, 5'd12, 32'hCAFEF00D);
      reset = 1'b1;
      #1;
      chk_all_zero("reset_mid");
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk_all_zero("reset_rel");

      // Wrap: 17 valid issues on a 4-bit counter.
      drive(0,0,1,1,0,0, 5'd1, 32'h00000001);
      for (int k = 1; k <= 17; k++) begin
         @(posedge clk);
         #1;
         if (k == 15) chk("wrap.issue15", {28'd0, issue_cnt}, 15);
         if (k == 16) chk("wrap.issue16", {28'd0, issue_cnt}, 0);
      end
      chk("wrap.issue17", {28'd0, issue_cnt}, 1);
      chk("wrap.bubble", {28'd0, bubble_cnt}, 0);
      chk("wrap.RdE", {27'd0, RdE}, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
